// File: rtl/cam_frame_writer.sv
// cam_frame_writer: crops the RGB565 capture stream to a programmable window and
// writes it into a double-banked frame buffer, swapping banks only on well-formed frames.
module cam_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X0       = 0,
  parameter int Y0       = 0,
  parameter int OUT_W    = 320,
  parameter int OUT_H    = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_pixel,
  input  logic              i_en,
  input  logic              i_vsync,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_wr_en,
  output logic              o_bank,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = $clog2(V_ACTIVE + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]        state;
  logic              vsync_d;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              ovf;

  logic rise;
  logic frame_ok;
  logic pix_acc_p0;
  logic line_ok;
  logic in_win;
  logic x_last;
  logic wr_vld_p0;

  assign rise     = i_vsync & ~vsync_d;
  assign frame_ok = (int'(y) == V_ACTIVE) && (x == '0) && !ovf;

  // A rise always has i_vsync high, so accepted strobes can never collide with frame end.
  assign pix_acc_p0 = (state == ST_ACTIVE) && i_en && !i_vsync;
  assign line_ok    = int'(y) < V_ACTIVE;
  assign in_win     = (int'(x) >= X0) && (int'(x) < X0 + OUT_W) &&
                      (int'(y) >= Y0) && (int'(y) < Y0 + OUT_H);
  assign x_last     = int'(x) == H_ACTIVE - 1;
  assign wr_vld_p0  = pix_acc_p0 && line_ok && in_win;

  assign o_busy = (state == ST_ACTIVE);

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      vsync_d      <= 1'b0;
      x            <= '0;
      y            <= '0;
      addr         <= '0;
      ovf          <= 1'b0;
      o_bank       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      vsync_d      <= i_vsync;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (rise) begin
        state <= ST_ACTIVE;
        x     <= '0;
        y     <= '0;
        addr  <= '0;
        ovf   <= 1'b0;
        if (state == ST_ACTIVE) begin
          if (frame_ok) begin
            o_frame_done <= 1'b1;
            o_bank       <= ~o_bank;
          end else begin
            o_frame_err  <= 1'b1;
          end
        end
      end else if (pix_acc_p0) begin
        if (!line_ok) begin
          ovf <= 1'b1;
        end else begin
          if (in_win) begin
            addr <= addr + 1'b1;
          end
          if (x_last) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
      end
    end
  end

  // Stage p0 -> p1: registered buffer write port, one cycle behind the strobe.
  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_data <= '0;
      o_wr_addr <= '0;
    end else begin
      o_wr_en <= wr_vld_p0;
      if (wr_vld_p0) begin
        o_wr_data <= i_pixel;
        o_wr_addr <= addr;
      end
    end
  end

endmodule
